// File: rtl/fft_peak_track.sv
// fft_peak_track: frame-aligned spectral peak search over FFT magnitude bins.
// Define PEAK_THRESH_EN to add the thresh input and no_signal output.
module fft_peak_track #(
  parameter int NFFT    = 8192,
  parameter int MAG_W   = 16,
  parameter int FREQ_W  = 24,
  parameter int BIN_HZ  = 200,
  parameter int DC_SKIP = 2,
  parameter int IDX_W   = $clog2(NFFT)
) (
  input  logic              fft_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAG_W-1:0]  mag_data,
  input  logic              mag_valid,
  input  logic              mag_last,
`ifdef PEAK_THRESH_EN
  input  logic [MAG_W-1:0]  thresh,
  output logic              no_signal,
`endif
  output logic [IDX_W-1:0]  peak_idx,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_valid,
  output logic              busy,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SEARCH,
    CALC,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0]  K_LAST = IDX_W'(NFFT - 1);
  localparam logic [IDX_W-1:0]  K_HALF = IDX_W'(NFFT / 2);
  localparam logic [IDX_W-1:0]  K_SKIP = IDX_W'(DC_SKIP);
  localparam logic [FREQ_W-1:0] HZ     = FREQ_W'(BIN_HZ);

  state_t            state_q;
  state_t            state_d;
  logic [IDX_W-1:0]  k_q;
  logic [IDX_W-1:0]  run_idx_q;
  logic [MAG_W-1:0]  run_max_q;
  logic              in_win;
  logic              at_end;
  logic              end_ok;
  logic              end_short;
  logic              end_long;
  logic              upd;
  logic              restart;
  logic              bad_end;
  logic [FREQ_W-1:0] calc_freq;

  assign in_win    = (k_q >= K_SKIP) && (k_q < K_HALF);
  assign at_end    = (k_q == K_LAST);
  assign end_ok    = mag_last & at_end;
  assign end_short = mag_last & ~at_end;
  assign end_long  = ~mag_last & at_end;

  assign busy = (state_q == ARMED)
              | (state_q == SEARCH)
              | (state_q == CALC);

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    bad_end = 1'b0;
    upd     = 1'b0;
    if (start) begin
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        ARMED: begin
          if (mag_valid && mag_last) begin
            state_d = SEARCH;
            restart = 1'b1;
          end
        end
        SEARCH: begin
          if (mag_valid) begin
            upd = in_win && (mag_data > run_max_q);
            unique case (1'b1)
              end_ok: state_d = CALC;
              // early last: this beat is the next frame's boundary
              end_short: begin
                restart = 1'b1;
                bad_end = 1'b1;
              end
              end_long: begin
                state_d = ARMED;
                bad_end = 1'b1;
              end
              default: begin
              end
            endcase
          end
        end
        CALC:    state_d = DONE;
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PEAK_THRESH_EN
  assign calc_freq = (run_max_q < thresh) ? '0
                   : FREQ_W'(run_idx_q) * HZ;

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      no_signal <= 1'b0;
    end else if (start) begin
      no_signal <= 1'b0;
    end else if (state_q == CALC) begin
      no_signal <= (run_max_q < thresh);
    end
  end
`else
  assign calc_freq = FREQ_W'(run_idx_q) * HZ;
`endif

  always_ff @(posedge fft_clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q        <= '0;
      run_idx_q  <= '0;
      run_max_q  <= '0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      freq       <= '0;
      freq_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= bad_end;
      if (start) begin
        k_q        <= '0;
        run_idx_q  <= K_SKIP;
        run_max_q  <= '0;
        peak_idx   <= '0;
        peak_mag   <= '0;
        freq       <= '0;
        freq_valid <= 1'b0;
      end else begin
        if (restart) begin
          // all-zero window reports the first searchable bin
          k_q       <= '0;
          run_idx_q <= K_SKIP;
          run_max_q <= '0;
        end else if (state_q == SEARCH && mag_valid) begin
          k_q <= k_q + IDX_W'(1);
          if (upd) begin
            run_max_q <= mag_data;
            run_idx_q <= k_q;
          end
        end
        if (state_q == CALC) begin
          peak_idx   <= run_idx_q;
          peak_mag   <= run_max_q;
          freq       <= calc_freq;
          freq_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_track.sv
// tb_fft_peak_track: scoreboard bench for fft_peak_track, NFFT=16.
// Reference model computes window argmax from each issued frame.
module tb_fft_peak_track;
  localparam int NFFT    = 16;
  localparam int MAG_W   = 16;
  localparam int FREQ_W  = 24;
  localparam int BIN_HZ  = 200;
  localparam int DC_SKIP = 1;
  localparam int IDX_W   = 4;

  logic              fft_clk   = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic              mag_valid = 1'b0;
  logic              mag_last  = 1'b0;
  logic [MAG_W-1:0]  mag_data  = '0;
  logic [IDX_W-1:0]  peak_idx;
  logic [MAG_W-1:0]  peak_mag;
  logic [FREQ_W-1:0] freq;
  logic              freq_valid;
  logic              busy;
  logic              frame_err;
`ifdef PEAK_THRESH_EN
  logic [MAG_W-1:0]  thresh = '0;
  logic              no_signal;
`endif

  always #5 fft_clk = ~fft_clk;

  fft_peak_track #(
    .NFFT(NFFT), .MAG_W(MAG_W), .FREQ_W(FREQ_W),
    .BIN_HZ(BIN_HZ), .DC_SKIP(DC_SKIP), .IDX_W(IDX_W)
  ) dut (
    .fft_clk(fft_clk),
    .rst_n(rst_n),
    .start(start),
    .mag_data(mag_data),
    .mag_valid(mag_valid),
    .mag_last(mag_last),
`ifdef PEAK_THRESH_EN
    .thresh(thresh),
    .no_signal(no_signal),
`endif
    .peak_idx(peak_idx),
    .peak_mag(peak_mag),
    .freq(freq),
    .freq_valid(freq_valid),
    .busy(busy),
    .frame_err(frame_err)
  );

  typedef struct {
    int idx;
    int mag;
    int freq;
    int nosig;
    int due;
  } exp_t;

  exp_t             sb[$];
  int               err_q[$];
  int               n_chk = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               last_edge = 0;
  logic [MAG_W-1:0] fr [NFFT];

  always @(posedge fft_clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endfunction

  // Monitor: pops the scoreboard on each result and each frame_err pulse.
  logic prev_fv = 1'b0;
  logic prev_fe = 1'b0;
  exp_t e;
  always @(negedge fft_clk) begin
    if (!rst_n) begin
      prev_fv = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (freq_valid && !prev_fv) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_freq_valid: got 1 at cycle %0d, expected 0", cyc);
        end else begin
          e = sb.pop_front();
          chk("peak_idx", 32'(peak_idx), e.idx);
          chk("peak_mag", 32'(peak_mag), e.mag);
          chk("freq", 32'(freq), e.freq);
          chk("result_cycle", cyc, e.due);
          chk("busy_at_result", 32'(busy), 0);
`ifdef PEAK_THRESH_EN
          chk("no_signal", 32'(no_signal), e.nosig);
`endif
        end
      end
      if (frame_err) begin
        chk("frame_err_width", 32'(prev_fe), 0);
        if (!prev_fe) begin
          if (err_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_frame_err: got 1 at cycle %0d, expected 0", cyc);
          end else begin
            chk("frame_err_cycle", cyc, err_q.pop_front());
          end
        end
      end
      prev_fv = freq_valid;
      prev_fe = frame_err;
    end
  end

  task automatic tick();
    @(posedge fft_clk);
    #1;
  endtask

  task automatic beat(input logic [MAG_W-1:0] d, input logic v, input logic l);
    mag_data  = d;
    mag_valid = v;
    mag_last  = l;
    tick();
    mag_valid = 1'b0;
    mag_last  = 1'b0;
  endtask

  task automatic send(input int n, input int last_at, input int pct);
    for (int k = 0; k < n; k++) begin
      while ($urandom_range(99) < pct)
        beat(MAG_W'($urandom), 1'b0, 1'($urandom));
      beat(fr[k], 1'b1, k == last_at);
    end
    last_edge = cyc;
  endtask

  task automatic expect_result();
    exp_t x;
    int mx;
    mx = 0;
    for (int k = DC_SKIP; k < NFFT / 2; k++)
      if (int'(fr[k]) > mx) mx = int'(fr[k]);
    x.idx = -1;
    for (int k = DC_SKIP; k < NFFT / 2; k++)
      if (x.idx < 0 && int'(fr[k]) == mx) x.idx = k;
    x.mag   = mx;
    x.freq  = x.idx * BIN_HZ;
    x.nosig = 0;
`ifdef PEAK_THRESH_EN
    if (mx < int'(thresh)) begin
      x.freq  = 0;
      x.nosig = 1;
    end
`endif
    x.due = last_edge + 1;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // start carries a full beat with mag_last that must be ignored
  task automatic arm();
    start     = 1'b1;
    mag_valid = 1'b1;
    mag_last  = 1'b1;
    mag_data  = MAG_W'($urandom);
    tick();
    start     = 1'b0;
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    chk("arm_busy", 32'(busy), 1);
    chk("arm_freq_valid", 32'(freq_valid), 0);
    chk("arm_peak_mag", 32'(peak_mag), 0);
    beat(MAG_W'($urandom), 1'b1, 1'b1);
  endtask

  task automatic fill(input int base);
    for (int k = 0; k < NFFT; k++) fr[k] = MAG_W'(base);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_peak_idx", 32'(peak_idx), 0);
    chk("rst_peak_mag", 32'(peak_mag), 0);
    chk("rst_freq", 32'(freq), 0);
    chk("rst_freq_valid", 32'(freq_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++)
      beat(MAG_W'($urandom), 1'b1, i == 4);
    fill(10);
    fr[5] = 900;
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();
    tick();
    chk("done_busy", 32'(busy), 0);
    chk("done_freq_valid", 32'(freq_valid), 1);

    fill(0);
    fr[3] = 500;
    fr[6] = 500;
    arm();
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();

    fill(0);
    fr[0]  = 4000;
    fr[10] = 5000;
    fr[7]  = 100;
    for (int r = 0; r < 2; r++) begin
      arm();
      send(NFFT, NFFT - 1, r * 40);
      expect_result();
      wait_done();
    end

    for (int k = 0; k < NFFT; k++) fr[k] = MAG_W'($urandom_range(50));
    arm();
    send(10, 9, 0);
    err_q.push_back(last_edge);
    fr[4] = 3000;
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();

    arm();
    send(NFFT, -1, 0);
    err_q.push_back(last_edge);
    beat(MAG_W'($urandom), 1'b1, 1'b1);
    fr[2] = 3500;
    send(NFFT, NFFT - 1, 10);
    expect_result();
    wait_done();

    arm();
    send(8, -1, 0);
    start     = 1'b1;
    mag_valid = 1'b1;
    mag_data  = fr[8];
    tick();
    start     = 1'b0;
    mag_valid = 1'b0;
    chk("mid_start_peak_idx", 32'(peak_idx), 0);
    chk("mid_start_peak_mag", 32'(peak_mag), 0);
    chk("mid_start_freq", 32'(freq), 0);
    chk("mid_start_freq_valid", 32'(freq_valid), 0);
    chk("mid_start_busy", 32'(busy), 1);
    send(NFFT, NFFT - 1, 0);
    fr[6] = 6000;
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();

    arm();
    send(6, -1, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_freq_valid", 32'(freq_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(NFFT, NFFT - 1, 0);
    send(NFFT, NFFT - 1, 0);
    repeat (3) tick();
    chk("idle_after_rst_busy", 32'(busy), 0);
    chk("idle_after_rst_freq_valid", 32'(freq_valid), 0);

    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < NFFT; k++) begin
        unique case (r % 3)
          0: fr[k] = MAG_W'($urandom);
          1: fr[k] = MAG_W'($urandom_range(3));
          default: fr[k] = '0;
        endcase
      end
      arm();
      send(NFFT, NFFT - 1, int'($urandom_range(30)));
      expect_result();
      wait_done();
    end

`ifdef PEAK_THRESH_EN
    thresh = 1000;
    fill(10);
    fr[5] = 900;
    arm();
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();
    fr[5] = 1200;
    arm();
    send(NFFT, NFFT - 1, 0);
    expect_result();
    wait_done();
    thresh = 0;
`endif

    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);
    chk("err_q_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_peak_track.md
# fft_peak_track

Parametrised spectral peak search for the frequency-measurement path. Consumes one frame of FFT magnitude bins per measurement on `fft_clk`, aligns to frame boundaries, and finds the largest bin in a configurable search window. Returns the peak bin, its magnitude and its frequency in Hz. Sits between the magnitude stage and the display/measurement logic. Adds frame checking, DC-bin exclusion, tie rules and a busy/valid handshake.

## Interface
- `NFFT`, 8192: bins per frame; power of two, 16 or more.
- `MAG_W`, 16: magnitude width (unsigned).
- `FREQ_W`, 24: frequency output width; `(NFFT/2-1)*BIN_HZ` must fit.
- `BIN_HZ`, 200: bin spacing in Hz; integer.
- `DC_SKIP`, 2: bins `0..DC_SKIP-1` are excluded from the search.
- `IDX_W`, `$clog2(NFFT)`: bin index width.

- `fft_clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `start` in 1: single-cycle request that arms a new measurement.
- `mag_data` in MAG_W: bin magnitude.
- `mag_valid` in 1: `mag_data` is valid this cycle.
- `mag_last` in 1: marks the final bin of a frame; qualified by `mag_valid`.
- `peak_idx` out IDX_W: bin index of the peak.
- `peak_mag` out MAG_W: magnitude of the peak.
- `freq` out FREQ_W: `peak_idx*BIN_HZ`, in Hz.
- `freq_valid` out 1: level; results are valid.
- `busy` out 1: high in ARMED, SEARCH and CALC.
- `frame_err` out 1: one-cycle pulse on a frame length mismatch.

## Operation
- States:
  - IDLE: reset state. `start` → ARMED.
  - ARMED: discards bins until a beat with `mag_valid & mag_last` → SEARCH. This guarantees alignment to a frame start.
  - SEARCH: a bin counter `k` starts at 0 and increments once per `mag_valid` beat. Gaps (`mag_valid=0`) hold all state.
  - CALC: one cycle; registers the results.
  - DONE: holds results with `freq_valid=1` until the next `start`.
- Search window is `DC_SKIP <= k < NFFT/2`. Bins outside the window are counted but never compared.
- Compare rule: update the running max only when `mag_data > max` (strictly greater). On a tie the lowest index wins. The running max is cleared to 0 when entering SEARCH.
- If every bin in the window is 0, the result is `peak_idx=DC_SKIP`, `peak_mag=0`.
- Frame end:
  - Beat `k==NFFT-1` with `mag_last=1` → CALC.
  - `mag_last=1` at `k<NFFT-1`: pulse `frame_err`; the beat counts as a frame boundary, so go straight to SEARCH with `k=0` and the max cleared.
  - `k==NFFT-1` without `mag_last`: pulse `frame_err` → ARMED.
- `start` in any state → ARMED. It clears `freq_valid`, `peak_idx`, `peak_mag`, `freq` and the running max. The data beat in the cycle `start` is sampled is ignored, including any `mag_last`.
- `freq = peak_idx * BIN_HZ`, computed in FREQ_W bits; the constant multiply is allowed to infer a DSP.

## Timing
- Reset values: all outputs 0, state IDLE.
- Let edge N be the edge that samples the last beat. CALC runs during cycle N+1. At edge N+1, `peak_idx`, `peak_mag`, `freq` and `freq_valid=1` are registered together.
- `busy` drops at the same edge that `freq_valid` rises.
- `frame_err` is high for exactly one cycle, in the cycle after the offending beat.
- Deasserting `rst_n` mid-frame returns the block to IDLE immediately. The next `start` requires a fresh frame boundary.
- Throughput: one bin per cycle, sustained indefinitely.

## Configuration
- `PEAK_THRESH_EN` defined:
  - Adds input `thresh` (MAG_W) and output `no_signal` (1, reset 0).
  - In CALC, if `peak_mag < thresh`: `no_signal=1` and `freq=0`. `peak_idx` and `peak_mag` still report the maximum. `freq_valid` rises as normal.
  - `no_signal` clears on `start`.
- `PEAK_THRESH_EN` undefined: no `thresh` or `no_signal` ports; `freq` always equals `peak_idx*BIN_HZ`.

## Test plan
All scenarios use `NFFT=16`, `BIN_HZ=200`, `DC_SKIP=1`.
- `start`, then a 5-beat partial frame ending in `mag_last`, then a full frame with bin 5 = 900 and all other bins 10 → `peak_idx=5`, `peak_mag=900`, `freq=1000`. `freq_valid` rises at edge N+1; `busy` is low from then on.
- Full frame with bins 3 and 6 both = 500, others 0 → `peak_idx=3`.
- Bin 0 = 4000, bin 10 = 5000, bin 7 = 100, others 0 → `peak_idx=7`, `freq=1400`. Repeat with random `mag_valid` gaps → same result.
- `mag_last` at beat 9 → one-cycle `frame_err`, no `freq_valid`. The next 16-bin frame with its peak at bin 4 → `freq=800`.
- `start` asserted at beat 8 of SEARCH → all results cleared, `busy=1`. Results appear only after a new boundary plus a full frame.
- With `PEAK_THRESH_EN` and `thresh=1000`: peak 900 at bin 5 → `no_signal=1`, `freq=0`, `peak_idx=5`, `freq_valid=1`. Rerun with a peak of 1200 → `no_signal=0`, `freq=1000`.
